// File: rtl/lsu_byte_seq.sv
// Load/store byte sequencer: splits one CPU request into 1/2/4 byte-wide memory
// accesses (lowest address first), assembles loads little-endian with
// sign/zero extension, and returns one response pulse per request.
module lsu_byte_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            AddrMode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [MEM_WIDTH-1:0]  mem_wd,
  input  logic [MEM_WIDTH-1:0]  mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] M_LB  = 3'b000;
  localparam logic [2:0] M_LH  = 3'b001;
  localparam logic [2:0] M_LW  = 3'b010;
  localparam logic [2:0] M_LBU = 3'b011;
  localparam logic [2:0] M_LHU = 3'b100;

  state_t                state_q;
  logic [2:0]            mode_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            idx_q, last_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  req_ready_q, rsp_valid_q, busy_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [MEM_WIDTH-1:0]  mem_wd_q;

  logic [DATA_WIDTH-1:0] asm_d, rdata_d;
  logic [1:0]            nidx;
  logic                  store_q, store_in;

  // Index of the last byte for a mode: byte ops 0, halfword ops 1, word ops 3.
  function automatic logic [1:0] last_idx(input logic [2:0] m);
    case (m)
      3'b000, 3'b011, 3'b101: last_idx = 2'd0;
      3'b001, 3'b100, 3'b110: last_idx = 2'd1;
      default:                last_idx = 2'd3;
    endcase
  endfunction

  assign store_q  = (mode_q >= 3'b101);
  assign store_in = (AddrMode >= 3'b101);
  assign nidx     = idx_q + 2'd1;

  // Merge the byte arriving this cycle and form the extended load result.
  always_comb begin
    asm_d = asm_q;
    asm_d[MEM_WIDTH*idx_q +: MEM_WIDTH] = mem_rd;
    rdata_d = '0;
    case (mode_q)
      M_LB:    rdata_d = {{(DATA_WIDTH-8){asm_d[7]}}, asm_d[7:0]};
      M_LH:    rdata_d = {{(DATA_WIDTH-16){asm_d[15]}}, asm_d[15:0]};
      M_LW:    rdata_d = asm_d;
      M_LBU:   rdata_d = {{(DATA_WIDTH-8){1'b0}}, asm_d[7:0]};
      M_LHU:   rdata_d = {{(DATA_WIDTH-16){1'b0}}, asm_d[15:0]};
      default: rdata_d = '0;
    endcase
  end

  // Control FSM; memory-port outputs are registered one edge ahead of their cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (req_valid) begin
            state_q     <= ACCESS;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            mode_q      <= AddrMode;
            wdata_q     <= wdata;
            idx_q       <= '0;
            last_q      <= last_idx(AddrMode);
            asm_q       <= '0;
            mem_addr_q  <= addr;
            mem_we_q    <= store_in;
            mem_wd_q    <= store_in ? wdata[MEM_WIDTH-1:0] : '0;
          end
        end
        ACCESS: begin
          asm_q <= asm_d;
          if (idx_q == last_q) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rdata_d;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wd_q    <= '0;
          end else begin
            idx_q      <= nidx;
            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            mem_wd_q   <= store_q ? wdata_q[MEM_WIDTH*nidx +: MEM_WIDTH] : '0;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wd_q    <= '0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wd    = mem_wd_q;

endmodule
